hsem_regfile: RTL and testbench

HSEM_REGFILE -- requirements
Module: hsem_regfile

---
 rtl/hsem_regfile.sv | 152 +++++++++++++++
 tb/tb_hsem_regfile.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsem_regfile.sv
// Hardware semaphore register file: NSEM lockable words, key-protected bulk
// release and an optional release-interrupt block (enabled by HSEM_IRQ_EN).
// Ports: hclk/hresetn clock and async low reset; wr_en/rd_en/reg_addr/
//        ihwdata/master_id data-phase access; ihrdata read data; irq.
module hsem_regfile #(
  parameter int NSEM = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] ihwdata,
  input  logic [3:0]  master_id,
  output logic [31:0] ihrdata,
  output logic        irq
);

  logic [31:0] sem_q [NSEM];
  logic [31:0] sem_d [NSEM];
  logic [15:0] keyr_q, keyr_d;
  logic [NSEM-1:0] set_v;

  logic        aligned;
  logic        is_r, is_rlr;
  logic        is_cr, is_keyr;
  logic        is_ier, is_icr;
  logic        is_isr, is_misr;
  logic [3:0]  idx;
  logic        rd_ok;
  logic        cr_ok;
  logic        hit;
  logic [31:0] hit_word;
  logic [31:0] new_word;
  logic [31:0] rlr_word;
  logic        unused_bits;

  assign aligned  = reg_addr[1:0] == 2'b00;
  assign is_r     = aligned && reg_addr[7:6] == 2'b00;
  assign is_rlr   = aligned && reg_addr[7:6] == 2'b01;
  assign is_cr    = reg_addr == 8'h80;
  assign is_keyr  = reg_addr == 8'h84;
  assign is_ier   = reg_addr == 8'h90;
  assign is_icr   = reg_addr == 8'h94;
  assign is_isr   = reg_addr == 8'h98;
  assign is_misr  = reg_addr == 8'h9C;
  assign idx      = reg_addr[5:2];
  // A write wins over a simultaneous read: no RLR lock then.
  assign rd_ok    = rd_en && !wr_en;
  assign cr_ok    = ihwdata[31:16] == keyr_q;
  assign new_word = {1'b1, 19'b0, ihwdata[11:0]};
  assign rlr_word = {1'b1, 19'b0, master_id, 8'h00};

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int i = 0; i < NSEM; i++) begin
      if (idx == 4'(i)) begin
        hit      = 1'b1;
        hit_word = sem_q[i];
      end
    end
  end

  always_comb begin
    keyr_d = keyr_q;
    set_v  = '0;
    for (int i = 0; i < NSEM; i++) begin
      sem_d[i] = sem_q[i];
      if (wr_en && is_r && idx == 4'(i)) begin
        if (ihwdata[31] && !sem_q[i][31]) begin
          sem_d[i] = new_word;
        end else if (!ihwdata[31] && sem_q[i][31] &&
                     sem_q[i][11:0] == ihwdata[11:0]) begin
          sem_d[i] = '0;
          set_v[i] = 1'b1;
        end
      end
      if (wr_en && is_cr && cr_ok && sem_q[i][31] &&
          sem_q[i][11:8] == ihwdata[11:8]) begin
        sem_d[i] = '0;
        set_v[i] = 1'b1;
      end
      if (rd_ok && is_rlr && idx == 4'(i) && !sem_q[i][31]) begin
        sem_d[i] = rlr_word;
      end
    end
    if (wr_en && is_keyr) begin
      keyr_d = ihwdata[31:16];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < NSEM; i++) sem_q[i] <= '0;
      keyr_q <= '0;
    end else begin
      for (int i = 0; i < NSEM; i++) sem_q[i] <= sem_d[i];
      keyr_q <= keyr_d;
    end
  end

`ifdef HSEM_IRQ_EN
  logic [NSEM-1:0] ier_q, ier_d;
  logic [NSEM-1:0] isr_q, isr_d;
  logic [NSEM-1:0] clr_v;

  always_comb begin
    ier_d = ier_q;
    clr_v = '0;
    if (wr_en && is_ier) ier_d = ihwdata[NSEM-1:0];
    if (wr_en && is_icr) clr_v = ihwdata[NSEM-1:0];
    // A release in the same cycle as a clear keeps the bit set.
    isr_d = (isr_q & ~clr_v) | set_v;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ier_q <= '0;
      isr_q <= '0;
    end else begin
      ier_q <= ier_d;
      isr_q <= isr_d;
    end
  end

  assign irq = |(isr_q & ier_q);
  assign unused_bits = ^{ihwdata[15:12], is_icr, is_cr};
`else
  assign irq = 1'b0;
  assign unused_bits = ^{ihwdata[15:12], set_v,
                         is_ier, is_icr, is_isr, is_misr, is_cr};
`endif

  always_comb begin
    ihrdata = '0;
    unique case (1'b1)
      is_r:    ihrdata = hit ? hit_word : '0;
      is_rlr: begin
        if (hit) ihrdata = hit_word[31] ? hit_word : rlr_word;
      end
      is_keyr: ihrdata = {keyr_q, 16'h0000};
`ifdef HSEM_IRQ_EN
      is_ier:  ihrdata = 32'(ier_q);
      is_isr:  ihrdata = 32'(isr_q);
      is_misr: ihrdata = 32'(isr_q & ier_q);
`endif
      default: ihrdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hsem_regfile.sv
// Bench for hsem_regfile: per-cycle compare against a semaphore model
// plus directed accesses with hand-computed literal expectations.
module tb_hsem_regfile;
  localparam int NSEM = 8;
`ifdef HSEM_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [31:0] MASK = (32'd1 << NSEM) - 32'd1;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] ihwdata = '0;
  logic [3:0]  master_id = '0;
  logic [31:0] ihrdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 hclk = ~hclk;

  hsem_regfile #(.NSEM(NSEM)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .wr_en(wr_en), .rd_en(rd_en),
    .reg_addr(reg_addr), .ihwdata(ihwdata),
    .master_id(master_id),
    .ihrdata(ihrdata), .irq(irq)
  );

  bit          m_lk [NSEM];
  int          m_core [NSEM];
  int          m_proc [NSEM];
  logic [15:0] m_key;
  logic [31:0] m_ier;
  logic [31:0] m_isr;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word(input int i);
    if (!m_lk[i]) return 32'h0;
    return 32'h8000_0000 + 32'(m_core[i]) * 256 + 32'(m_proc[i]);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] a,
                                          input logic [3:0] m);
    int i;
    if (a[1:0] != 2'b00) return 32'h0;
    if (a < 8'h40) begin
      i = int'(a) / 4;
      return (i < NSEM) ? m_word(i) : 32'h0;
    end
    if (a < 8'h80) begin
      i = (int'(a) - 64) / 4;
      if (i >= NSEM) return 32'h0;
      return m_lk[i] ? m_word(i) : 32'h8000_0000 + 32'(m) * 256;
    end
    case (a)
      8'h84:   return {m_key, 16'h0000};
      8'h90:   return IRQ ? m_ier : 32'h0;
      8'h98:   return IRQ ? m_isr : 32'h0;
      8'h9C:   return IRQ ? (m_isr & m_ier) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge hclk) begin : mdl
    logic [31:0] set_b;
    logic [31:0] clr_b;
    int i;
    set_b = '0;
    clr_b = '0;
    if (!hresetn) begin
      for (int j = 0; j < NSEM; j++) begin
        m_lk[j] = 1'b0; m_core[j] = 0; m_proc[j] = 0;
      end
      m_key = '0; m_ier = '0; m_isr = '0;
      chk("irq_in_reset", {31'b0, irq}, 32'h0);
    end else begin
      if (rd_en && !wr_en)
        chk("rdata", ihrdata, exp_rd(reg_addr, master_id));
      chk("irq", {31'b0, irq},
          (IRQ && (m_isr & m_ier) != 0) ? 32'h1 : 32'h0);
      if (wr_en && reg_addr[1:0] == 2'b00) begin
        if (reg_addr < 8'h40) begin
          i = int'(reg_addr) / 4;
          if (i < NSEM) begin
            if (ihwdata[31] && !m_lk[i]) begin
              m_lk[i] = 1'b1;
              m_core[i] = int'(ihwdata[11:8]);
              m_proc[i] = int'(ihwdata[7:0]);
            end else if (!ihwdata[31] && m_lk[i] &&
                         m_core[i] == int'(ihwdata[11:8]) &&
                         m_proc[i] == int'(ihwdata[7:0])) begin
              m_lk[i] = 1'b0;
              set_b[i] = 1'b1;
            end
          end
        end else if (reg_addr == 8'h80) begin
          if (ihwdata[31:16] == m_key)
            for (int j = 0; j < NSEM; j++)
              if (m_lk[j] && m_core[j] == int'(ihwdata[11:8])) begin
                m_lk[j] = 1'b0;
                set_b[j] = 1'b1;
              end
        end else if (reg_addr == 8'h84) begin
          m_key = ihwdata[31:16];
        end else if (reg_addr == 8'h90) begin
          if (IRQ) m_ier = ihwdata & MASK;
        end else if (reg_addr == 8'h94) begin
          clr_b = ihwdata & MASK;
        end
      end else if (rd_en && !wr_en && reg_addr[1:0] == 2'b00 &&
                   reg_addr >= 8'h40 && reg_addr < 8'h80) begin
        i = (int'(reg_addr) - 64) / 4;
        if (i < NSEM && !m_lk[i]) begin
          m_lk[i] = 1'b1;
          m_core[i] = int'(master_id);
          m_proc[i] = 0;
        end
      end
      if (IRQ) m_isr = (m_isr & ~clr_b) | set_b;
    end
  end

  task automatic acc(input bit w, input bit r, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] q);
    @(posedge hclk); #1;
    wr_en = w; rd_en = r; reg_addr = a; ihwdata = d; master_id = m;
    @(negedge hclk); #1;
    q = ihrdata;
    @(posedge hclk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    acc(1'b1, 1'b0, a, d, 4'h0, q);
  endtask

  task automatic rd(input logic [7:0] a, input logic [3:0] m,
                    input logic [31:0] e, input string n);
    logic [31:0] q;
    acc(1'b0, 1'b1, a, 32'h0, m, q);
    chk(n, q, e);
  endtask

  initial begin
    logic [31:0] q;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    rd(8'h00, 4'h0, 32'h0, "rst_r0");
    rd(8'h84, 4'h0, 32'h0, "rst_keyr");

    wr(8'h08, 32'h8000_0305);
    rd(8'h08, 4'h0, 32'h8000_0305, "r2_lock");
    wr(8'h08, 32'h8000_0407);
    rd(8'h08, 4'h0, 32'h8000_0305, "r2_relock");
    wr(8'h08, 32'h0000_0304);
    rd(8'h08, 4'h0, 32'h8000_0305, "r2_bad_unlock");
    wr(8'h90, 32'h0000_0004);
    wr(8'h08, 32'h0000_0305);
    chk("irq_after_unlock", {31'b0, irq}, IRQ ? 32'h1 : 32'h0);
    rd(8'h08, 4'h0, 32'h0, "r2_free");
    rd(8'h98, 4'h0, IRQ ? 32'h4 : 32'h0, "isr_unlock");
    rd(8'h9C, 4'h0, IRQ ? 32'h4 : 32'h0, "misr_unlock");

    rd(8'h54, 4'h3, 32'h8000_0300, "rlr5_first");
    rd(8'h54, 4'h1, 32'h8000_0300, "rlr5_second");
    rd(8'h14, 4'h0, 32'h8000_0300, "r5_after_rlr");
    wr(8'h14, 32'h0000_0300);
    wr(8'h94, 32'h0000_FFFF);
    rd(8'h98, 4'h0, 32'h0, "isr_cleared");

    wr(8'h84, 32'hA5A5_0000);
    rd(8'h84, 4'h0, 32'hA5A5_0000, "keyr");
    wr(8'h00, 32'h8000_0311);
    wr(8'h04, 32'h8000_0312);
    wr(8'h10, 32'h8000_0120);
    wr(8'h80, 32'h1234_0300);
    rd(8'h00, 4'h0, 32'h8000_0311, "cr_badkey_r0");
    rd(8'h98, 4'h0, 32'h0, "cr_badkey_isr");
    wr(8'h80, 32'hA5A5_0300);
    rd(8'h00, 4'h0, 32'h0, "cr_r0");
    rd(8'h04, 4'h0, 32'h0, "cr_r1");
    rd(8'h10, 4'h0, 32'h8000_0120, "cr_r4_kept");
    rd(8'h98, 4'h0, IRQ ? 32'h3 : 32'h0, "isr_cr");

    wr(8'h94, 32'h0000_00FF);
    wr(8'h90, 32'h0000_0001);
    wr(8'h00, 32'h8000_0101);
    wr(8'h00, 32'h0000_0101);
    chk("irq_isr0", {31'b0, irq}, IRQ ? 32'h1 : 32'h0);
    rd(8'h98, 4'h0, IRQ ? 32'h1 : 32'h0, "isr0_set");
    wr(8'h94, 32'h0000_0001);
    rd(8'h98, 4'h0, 32'h0, "isr0_clr");
    chk("irq_clr", {31'b0, irq}, 32'h0);

    rd(8'h80, 4'h0, 32'h0, "cr_reads0");
    rd(8'h94, 4'h0, 32'h0, "icr_reads0");
    wr(8'hA0, 32'hFFFF_FFFF);
    rd(8'hA0, 4'h0, 32'h0, "unmapped");
    wr(8'h20, 32'h8000_0111);
    rd(8'h20, 4'h0, 32'h0, "r8_oob");
    rd(8'h60, 4'h2, 32'h0, "rlr8_oob");

    acc(1'b1, 1'b1, 8'h4C, 32'h8000_0233, 4'h2, q);
    rd(8'h0C, 4'h0, 32'h0, "both_strobes");

    wr(8'h84, 32'h5555_0000);
    wr(8'h90, 32'h0000_00FF);
    @(posedge hclk); #1;
    rd_en = 1'b1; reg_addr = 8'h44; master_id = 4'h2;
    #2 hresetn = 1'b0;
    #1 chk("irq_reset", {31'b0, irq}, 32'h0);
    @(posedge hclk); #1 rd_en = 1'b0;
    @(posedge hclk); #1 hresetn = 1'b1;
    rd(8'h04, 4'h0, 32'h0, "rst_r1");
    rd(8'h10, 4'h0, 32'h0, "rst_r4");
    rd(8'h84, 4'h0, 32'h0, "rst_keyr2");
    rd(8'h90, 4'h0, 32'h0, "rst_ier");

    repeat (2) @(posedge hclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
